// File: rtl/vend_credit_fsm.sv
// Vending-machine credit controller: keypad coin/select/cancel events drive credit, vend and refund.
// Optional idle-credit timeout is compiled in with `define VEND_TIMEOUT_EN.
module vend_credit_fsm #(
   parameter logic [7:0]  PRICE_A        = 8'd25,
   parameter logic [7:0]  PRICE_B        = 8'd50,
   parameter logic [7:0]  PRICE_C        = 8'd75,
   parameter logic [7:0]  PRICE_D        = 8'd100,
   parameter logic [7:0]  CREDIT_MAX     = 8'd250,
   parameter logic [15:0] DISP_CYCLES    = 16'd50000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic [7:0] credit,
   output logic       dispense,
   output logic [1:0] product,
   output logic [7:0] change,
   output logic       change_valid,
   output logic       busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CREDIT = 2'd1;
   localparam logic [1:0] S_VEND   = 2'd2;
   localparam logic [1:0] S_REFUND = 2'd3;

   logic [1:0]  state;
   logic        armed;
   logic        key_q;
   logic        key_evt;
   logic [3:0]  key_code_q;
   logic [7:0]  pend_chg;
   logic [15:0] disp_cnt;
   logic        to_hit;

   logic        is_coin, is_sel, is_cancel;
   logic [7:0]  coin_val;
   logic [1:0]  sel_idx;
   logic [7:0]  sel_price;
   logic [8:0]  coin_sum;
   logic        coin_ovf;
   logic        can_buy;

   // armed stays low for the first edge after reset so a key held through
   // reset only primes key_q and never looks like a fresh press
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed      <= 1'b0;
         key_q      <= 1'b0;
         key_evt    <= 1'b0;
         key_code_q <= 4'd0;
      end else begin
         armed   <= 1'b1;
         key_q   <= key_valid;
         key_evt <= armed & key_valid & ~key_q;
         if (armed & key_valid & ~key_q)
            key_code_q <= key_code;
      end
   end

   always_comb begin
      is_coin   = 1'b0;
      is_sel    = 1'b0;
      is_cancel = 1'b0;
      coin_val  = 8'd0;
      sel_idx   = 2'd0;
      case (key_code_q)
         4'h1: begin is_coin = 1'b1; coin_val = 8'd5;  end
         4'h2: begin is_coin = 1'b1; coin_val = 8'd10; end
         4'h5: begin is_coin = 1'b1; coin_val = 8'd25; end
         4'hA: begin is_sel = 1'b1; sel_idx = 2'd0; end
         4'hB: begin is_sel = 1'b1; sel_idx = 2'd1; end
         4'hC: begin is_sel = 1'b1; sel_idx = 2'd2; end
         4'hD: begin is_sel = 1'b1; sel_idx = 2'd3; end
         4'hE: is_cancel = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      case (sel_idx)
         2'd0:    sel_price = PRICE_A;
         2'd1:    sel_price = PRICE_B;
         2'd2:    sel_price = PRICE_C;
         default: sel_price = PRICE_D;
      endcase
   end

   assign coin_sum = {1'b0, credit} + {1'b0, coin_val};
   assign coin_ovf = coin_sum > {1'b0, CREDIT_MAX};
   assign can_buy  = credit >= sel_price;
   assign busy     = (state == S_VEND) || (state == S_REFUND);

`ifdef VEND_TIMEOUT_EN
   logic [31:0] to_cnt;

   assign to_hit = (state == S_CREDIT) && (to_cnt == TIMEOUT_CYCLES - 32'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         to_cnt <= 32'd0;
      else if (state != S_CREDIT || key_evt || to_hit)
         to_cnt <= 32'd0;
      else
         to_cnt <= to_cnt + 32'd1;
   end
`else
   // timeout compiled out; the parameter stays referenced so the interface is identical
   assign to_hit = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         credit       <= 8'd0;
         change       <= 8'd0;
         change_valid <= 1'b0;
         product      <= 2'd0;
         dispense     <= 1'b0;
         pend_chg     <= 8'd0;
         disp_cnt     <= 16'd0;
      end else begin
         change_valid <= 1'b0;
         case (state)
            S_IDLE, S_CREDIT: begin
               if (key_evt) begin
                  if (is_coin) begin
                     // an over-ceiling coin is handed straight back, credit untouched
                     if (coin_ovf) begin
                        change       <= coin_val;
                        change_valid <= 1'b1;
                     end else begin
                        credit <= coin_sum[7:0];
                        state  <= S_CREDIT;
                     end
                  end else if (is_sel && can_buy) begin
                     state    <= S_VEND;
                     product  <= sel_idx;
                     dispense <= 1'b1;
                     pend_chg <= credit - sel_price;
                     disp_cnt <= 16'd0;
                  end else if (is_cancel && state == S_CREDIT) begin
                     state    <= S_REFUND;
                     pend_chg <= credit;
                  end
               end else if (to_hit) begin
                  state    <= S_REFUND;
                  pend_chg <= credit;
               end
            end
            S_VEND: begin
               if (disp_cnt == DISP_CYCLES - 16'd1) begin
                  dispense <= 1'b0;
                  state    <= S_REFUND;
               end else begin
                  disp_cnt <= disp_cnt + 16'd1;
               end
            end
            S_REFUND: begin
               change       <= pend_chg;
               change_valid <= 1'b1;
               credit       <= 8'd0;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm: coin/select/cancel/overflow/reset/timeout sequences.
module tb_vend_credit_fsm;

   localparam logic [15:0] DISP = 16'd8;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_code;
   logic       key_valid;
   logic [7:0] credit;
   logic       dispense;
   logic [1:0] product;
   logic [7:0] change;
   logic       change_valid;
   logic       busy;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;
   int n;
   logic seen;

   vend_credit_fsm #(
      .DISP_CYCLES(DISP),
      .TIMEOUT_CYCLES(32'd100)
   ) dut (
      .clk(clk),
      .reset(reset),
      .key_code(key_code),
      .key_valid(key_valid),
      .credit(credit),
      .dispense(dispense),
      .product(product),
      .change(change),
      .change_valid(change_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // key rises before edge 1 (event registered), FSM acts on edge 2
   task automatic press_start(input logic [3:0] c);
      key_code  = c;
      key_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic release_key();
      key_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] c);
      press_start(c);
      release_key();
   endtask

   initial begin
      reset     = 1'b1;
      key_valid = 1'b1;
      key_code  = 4'h5;
      repeat (3) @(negedge clk);
      check("rst_credit", credit, 0);
      check("rst_dispense", dispense, 0);
      check("rst_cv", change_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_change", change, 0);
      check("rst_product", product, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("held_key_no_event", credit, 0);
      key_valid = 1'b0;
      repeat (2) @(negedge clk);

      // three quarters then product B
      press(4'h5); check("coin25_a", credit, 25);
      press(4'h5); check("coin25_b", credit, 50);
      press(4'h5); check("coin25_c", credit, 75);
      press_start(4'hB);
      check("vendB_dispense", dispense, 1);
      check("vendB_product", product, 1);
      check("vendB_busy", busy, 1);
      key_valid = 1'b0;
      n = 0;
      while (dispense === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("vendB_len", n, DISP);
      check("vendB_refund_busy", busy, 1);
      @(negedge clk);
      check("vendB_cv", change_valid, 1);
      check("vendB_change", change, 25);
      check("vendB_credit", credit, 0);
      check("vendB_idle", busy, 0);
      @(negedge clk);
      check("vendB_cv_pulse", change_valid, 0);
      check("vendB_change_hold", change, 25);

      // insufficient credit for D
      press(4'h2); check("coin10", credit, 10);
      press(4'hD);
      check("selD_low_credit", credit, 10);
      check("selD_no_dispense", dispense, 0);
      check("selD_not_busy", busy, 0);
      press_start(4'hE);
      release_key();
      check("cancel10_cv", change_valid, 1);
      check("cancel10_change", change, 10);
      check("cancel10_credit", credit, 0);

      // ceiling overflow
      for (int i = 0; i < 9; i++) press(4'h5);
      press(4'h2);
      press(4'h2);
      check("credit245", credit, 245);
      press_start(4'h2);
      check("ovf_cv", change_valid, 1);
      check("ovf_change", change, 10);
      check("ovf_credit", credit, 245);
      release_key();
      check("ovf_cv_pulse", change_valid, 0);
      check("ovf_credit_hold", credit, 245);
      press_start(4'hE);
      release_key();
      check("cancel245_change", change, 245);
      check("cancel245_credit", credit, 0);

      // cancel with 35, then cancel in IDLE
      press(4'h5);
      press(4'h2);
      check("credit35", credit, 35);
      press_start(4'hE);
      release_key();
      check("cancel35_cv", change_valid, 1);
      check("cancel35_change", change, 35);
      check("cancel35_credit", credit, 0);
      check("cancel35_idle", busy, 0);
      press_start(4'hE);
      release_key();
      check("cancel_idle_no_cv", change_valid, 0);
      check("cancel_idle_change_hold", change, 35);

      // coin pressed during VEND is discarded
      press(4'h5);
      press_start(4'hA);
      check("vendA_dispense", dispense, 1);
      check("vendA_product", product, 0);
      release_key();
      press(4'h1);
      n = 0;
      while (dispense === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("vendA_len_rest", n, DISP - 4);
      @(negedge clk);
      check("vendA_cv", change_valid, 1);
      check("vendA_change0", change, 0);
      check("vendA_credit", credit, 0);

      // reset in the middle of a vend
      press(4'h5);
      press_start(4'hA);
      key_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midvend_dispense", dispense, 1);
      #2 reset = 1'b1;
      #1;
      check("rstvend_dispense", dispense, 0);
      check("rstvend_busy", busy, 0);
      check("rstvend_credit", credit, 0);
      check("rstvend_cv", change_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (change_valid === 1'b1) seen = 1'b1;
      end
      check("rstvend_no_pulse", seen, 0);
      check("rstvend_idle_credit", credit, 0);

      // idle credit of 20
      press(4'h2);
      press(4'h2);
      check("credit20", credit, 20);
      n = 0;
      while (change_valid !== 1'b1 && n < 150) begin
         @(negedge clk);
         n++;
      end
`ifdef VEND_TIMEOUT_EN
      check("timeout_cv", change_valid, 1);
      check("timeout_change", change, 20);
      check("timeout_credit", credit, 0);
`else
      check("no_timeout_cv", change_valid, 0);
      check("no_timeout_credit", credit, 20);
      check("no_timeout_busy", busy, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
